// File: rtl/sys_defs.sv
// Shared register-file sizing, register-id types and the retire FSM state enum.
`ifndef NUM_AREGS
`define NUM_AREGS 32
`endif
`ifndef NUM_PREGS
`define NUM_PREGS 64
`endif

package sys_defs;

  localparam int unsigned AREG_W = $clog2(`NUM_AREGS);
  localparam int unsigned PREG_W = $clog2(`NUM_PREGS);

  typedef logic [AREG_W-1:0] AREG;
  typedef logic [PREG_W-1:0] PREG;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    RECOVER = 2'd2
  } retire_state_e;

endpackage

// File: rtl/retire_bypass.sv
// Per-port old-preg selection for a retire group, with forwarding from older
// ports that write the same areg in the same cycle, plus the resulting map.
module retire_bypass
  import sys_defs::*;
#(
  parameter int RETIRE_PORTS = 2,
  parameter int NUM_AREGS    = `NUM_AREGS
) (
  input  logic [RETIRE_PORTS-1:0] i_we,
  input  AREG  [RETIRE_PORTS-1:0] i_areg,
  input  PREG  [RETIRE_PORTS-1:0] i_preg,
  input  PREG  [NUM_AREGS-1:0]    i_map,
  output PREG  [RETIRE_PORTS-1:0] o_old_preg,
  output logic [RETIRE_PORTS-1:0] o_free_en,
  output PREG  [NUM_AREGS-1:0]    o_next_map
);

  // Ports are applied oldest first onto a working copy of the map, so a
  // younger port naming the same areg sees the older port's preg as "old".
  always_comb begin
    o_old_preg = '0;
    o_free_en  = '0;
    o_next_map = i_map;
    for (int unsigned i = 0; i < RETIRE_PORTS; i++) begin
      o_old_preg[i] = o_next_map[i_areg[i]];
      if (i_we[i]) begin
        o_free_en[i]            = (o_old_preg[i] != '0);
        o_next_map[i_areg[i]]   = i_preg[i];
      end
    end
  end

endmodule

// File: rtl/retire_map.sv
// Committed architectural map: frees displaced pregs one cycle after retire
// and publishes the in-use preg set for squash recovery.
module retire_map
  import sys_defs::*;
#(
  parameter int RETIRE_PORTS = 2,
  parameter int NUM_AREGS    = `NUM_AREGS,
  parameter int NUM_PREGS    = `NUM_PREGS
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [RETIRE_PORTS-1:0] ret_valid,
  input  logic [RETIRE_PORTS-1:0] ret_has_dest,
  input  AREG  [RETIRE_PORTS-1:0] ret_areg,
  input  PREG  [RETIRE_PORTS-1:0] ret_preg,
  input  logic                    rewind,
  output PREG  [RETIRE_PORTS-1:0] preg_to_free,
  output logic [RETIRE_PORTS-1:0] free_en,
  output logic                    ret_ready,
  output logic                    recover_valid,
  output logic [NUM_PREGS-1:0]    recover_inuse,
  output PREG  [NUM_AREGS-1:0]    arch_map
);

  retire_state_e           r_state;
  retire_state_e           w_state_nxt;
  PREG  [NUM_AREGS-1:0]    r_map;
  PREG  [NUM_AREGS-1:0]    w_next_map;
  PREG  [RETIRE_PORTS-1:0] w_old_preg;
  PREG  [RETIRE_PORTS-1:0] r_preg_to_free;
  logic [RETIRE_PORTS-1:0] w_we;
  logic [RETIRE_PORTS-1:0] w_free;
  logic [RETIRE_PORTS-1:0] r_free_en;
  logic                    w_run;

  always_comb begin
    w_state_nxt   = r_state;
    w_run         = 1'b0;
    recover_valid = 1'b0;
    case (r_state)
      RUN: begin
        w_run = 1'b1;
        if (rewind) w_state_nxt = DRAIN;
      end
      DRAIN:   w_state_nxt = RECOVER;
      RECOVER: begin
        recover_valid = 1'b1;
        w_state_nxt   = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
    // Held low while reset is applied even though the state already reads RUN.
    ret_ready = w_run & reset_n;
  end

  assign w_we = ret_valid & ret_has_dest & {RETIRE_PORTS{ret_ready}};

  retire_bypass #(
    .RETIRE_PORTS (RETIRE_PORTS),
    .NUM_AREGS    (NUM_AREGS)
  ) u_bypass (
    .i_we       (w_we),
    .i_areg     (ret_areg),
    .i_preg     (ret_preg),
    .i_map      (r_map),
    .o_old_preg (w_old_preg),
    .o_free_en  (w_free),
    .o_next_map (w_next_map)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= RUN;
      r_free_en      <= '0;
      r_preg_to_free <= '0;
      for (int unsigned a = 0; a < NUM_AREGS; a++) begin
        r_map[a] <= PREG'(a);
      end
    end else begin
      r_state   <= w_state_nxt;
      r_map     <= w_next_map;
      r_free_en <= w_free;
      for (int unsigned i = 0; i < RETIRE_PORTS; i++) begin
        r_preg_to_free[i] <= w_free[i] ? w_old_preg[i] : '0;
      end
    end
  end

  always_comb begin
    recover_inuse = '0;
    for (int unsigned a = 0; a < NUM_AREGS; a++) begin
      recover_inuse[r_map[a]] = 1'b1;
    end
    recover_inuse[0] = 1'b1;
  end

  assign free_en      = r_free_en;
  assign preg_to_free = r_preg_to_free;
  assign arch_map     = r_map;

endmodule

// File: tb/tb_retire_map.sv
// Scenario tasks plus a randomized retire stream checked against a
// map/free-pool reference model kept in the bench.
module tb_retire_map;
  import sys_defs::*;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [1:0]      ret_valid;
  logic [1:0]      ret_has_dest;
  AREG  [1:0]      ret_areg;
  PREG  [1:0]      ret_preg;
  logic            rewind;
  PREG  [1:0]      preg_to_free;
  logic [1:0]      free_en;
  logic            ret_ready;
  logic            recover_valid;
  logic [63:0]     recover_inuse;
  PREG  [31:0]     arch_map;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  retire_map #(
    .RETIRE_PORTS (2),
    .NUM_AREGS    (32),
    .NUM_PREGS    (64)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ret_valid     (ret_valid),
    .ret_has_dest  (ret_has_dest),
    .ret_areg      (ret_areg),
    .ret_preg      (ret_preg),
    .rewind        (rewind),
    .preg_to_free  (preg_to_free),
    .free_en       (free_en),
    .ret_ready     (ret_ready),
    .recover_valid (recover_valid),
    .recover_inuse (recover_inuse),
    .arch_map      (arch_map)
  );

  task automatic drive(input logic [1:0] v, input logic [1:0] hd, input int a0, input int p0,
                       input int a1, input int p1, input logic rw);
    @(negedge clock);
    ret_valid    = v;
    ret_has_dest = hd;
    ret_areg[0]  = AREG'(a0);
    ret_preg[0]  = PREG'(p0);
    ret_areg[1]  = AREG'(a1);
    ret_preg[1]  = PREG'(p1);
    rewind       = rw;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    ret_valid = '0; ret_has_dest = '0; ret_areg = '0; ret_preg = '0; rewind = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    PREG [31:0] ident;
    for (int a = 0; a < 32; a++) ident[a] = PREG'(a);
    reset_n = 1'b1;
    ret_valid = '0; ret_has_dest = '0; ret_areg = '0; ret_preg = '0; rewind = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (free_en !== 2'b00) begin errors++; $display("FAIL reset_free_en: got %b expected 00", free_en); end
    checks++; if (preg_to_free !== '0) begin errors++; $display("FAIL reset_preg_to_free: got %h expected 0", preg_to_free); end
    checks++; if (recover_valid !== 1'b0) begin errors++; $display("FAIL reset_recover_valid: got %b expected 0", recover_valid); end
    checks++; if (ret_ready !== 1'b0) begin errors++; $display("FAIL reset_ret_ready_low: got %b expected 0", ret_ready); end
    checks++; if (arch_map !== ident) begin errors++; $display("FAIL reset_identity: got %h expected %h", arch_map, ident); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++; if (ret_ready !== 1'b1) begin errors++; $display("FAIL reset_ret_ready_high: got %b expected 1", ret_ready); end
  endtask

  task automatic test_single();
    drive(2'b01, 2'b01, 5, 40, 0, 0, 1'b0);
    @(posedge clock); #1;
    checks++; if (free_en !== 2'b01) begin errors++; $display("FAIL single_free_en: got %b expected 01", free_en); end
    checks++; if (preg_to_free[0] !== PREG'(5)) begin errors++; $display("FAIL single_preg: got %0d expected 5", preg_to_free[0]); end
    checks++; if (arch_map[5] !== PREG'(40)) begin errors++; $display("FAIL single_map: got %0d expected 40", arch_map[5]); end
    idle();
    @(posedge clock); #1;
    checks++; if (free_en !== 2'b00) begin errors++; $display("FAIL single_free_drop: got %b expected 00", free_en); end
  endtask

  task automatic test_same_areg();
    drive(2'b11, 2'b11, 3, 41, 3, 42, 1'b0);
    @(posedge clock); #1;
    checks++; if (free_en !== 2'b11) begin errors++; $display("FAIL same_free_en: got %b expected 11", free_en); end
    checks++; if (preg_to_free[0] !== PREG'(3)) begin errors++; $display("FAIL same_preg0: got %0d expected 3", preg_to_free[0]); end
    checks++; if (preg_to_free[1] !== PREG'(41)) begin errors++; $display("FAIL same_preg1: got %0d expected 41", preg_to_free[1]); end
    checks++; if (arch_map[3] !== PREG'(42)) begin errors++; $display("FAIL same_map: got %0d expected 42", arch_map[3]); end
    idle();
  endtask

  task automatic test_preg0();
    // port0 displaces preg 0, port1 is valid but writes no register
    drive(2'b11, 2'b01, 0, 43, 4, 44, 1'b0);
    @(posedge clock); #1;
    checks++; if (free_en !== 2'b00) begin errors++; $display("FAIL preg0_free_en: got %b expected 00", free_en); end
    checks++; if (arch_map[0] !== PREG'(43)) begin errors++; $display("FAIL preg0_map0: got %0d expected 43", arch_map[0]); end
    checks++; if (arch_map[4] !== PREG'(4)) begin errors++; $display("FAIL nodest_map4: got %0d expected 4", arch_map[4]); end
    idle();
  endtask

  task automatic test_rewind();
    do_reset();
    drive(2'b01, 2'b01, 7, 50, 0, 0, 1'b1);
    @(posedge clock); #1;
    checks++; if (free_en !== 2'b01) begin errors++; $display("FAIL drain_free_en: got %b expected 01", free_en); end
    checks++; if (preg_to_free[0] !== PREG'(7)) begin errors++; $display("FAIL drain_preg: got %0d expected 7", preg_to_free[0]); end
    checks++; if (ret_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b expected 0", ret_ready); end
    checks++; if (recover_valid !== 1'b0) begin errors++; $display("FAIL drain_recover: got %b expected 0", recover_valid); end
    drive(2'b01, 2'b01, 8, 51, 0, 0, 1'b1);
    @(posedge clock); #1;
    checks++; if (recover_valid !== 1'b1) begin errors++; $display("FAIL recover_valid: got %b expected 1", recover_valid); end
    checks++; if (recover_inuse[50] !== 1'b1) begin errors++; $display("FAIL inuse50: got %b expected 1", recover_inuse[50]); end
    checks++; if (recover_inuse[7] !== 1'b0) begin errors++; $display("FAIL inuse7: got %b expected 0", recover_inuse[7]); end
    checks++; if (recover_inuse[0] !== 1'b1) begin errors++; $display("FAIL inuse0: got %b expected 1", recover_inuse[0]); end
    checks++; if (free_en !== 2'b00) begin errors++; $display("FAIL recover_free_en: got %b expected 00", free_en); end
    checks++; if (arch_map[8] !== PREG'(8)) begin errors++; $display("FAIL drain_ignored: got %0d expected 8", arch_map[8]); end
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    @(posedge clock); #1;
    checks++; if (recover_valid !== 1'b0) begin errors++; $display("FAIL recover_pulse: got %b expected 0", recover_valid); end
    checks++; if (ret_ready !== 1'b1) begin errors++; $display("FAIL back_to_run: got %b expected 1", ret_ready); end
    idle();
  endtask

  task automatic test_reset_recover();
    do_reset();
    drive(2'b01, 2'b01, 9, 52, 0, 0, 1'b1);
    @(posedge clock);
    idle();
    @(posedge clock); #1;
    checks++; if (recover_valid !== 1'b1) begin errors++; $display("FAIL rr_enter: got %b expected 1", recover_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (recover_valid !== 1'b0) begin errors++; $display("FAIL rr_abort: got %b expected 0", recover_valid); end
    checks++; if (free_en !== 2'b00) begin errors++; $display("FAIL rr_free_en: got %b expected 00", free_en); end
    checks++; if (arch_map[9] !== PREG'(9)) begin errors++; $display("FAIL rr_map: got %0d expected 9", arch_map[9]); end
    checks++; if (ret_ready !== 1'b0) begin errors++; $display("FAIL rr_ready: got %b expected 0", ret_ready); end
    @(posedge clock); #1;
    checks++; if (recover_valid !== 1'b0) begin errors++; $display("FAIL rr_held: got %b expected 0", recover_valid); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++; if (recover_valid !== 1'b0) begin errors++; $display("FAIL rr_after: got %b expected 0", recover_valid); end
    checks++; if (ret_ready !== 1'b1) begin errors++; $display("FAIL rr_ready_after: got %b expected 1", ret_ready); end
  endtask

  task automatic test_random();
    int mmap [32];
    int freed_cnt [64];
    int pool [$];
    int exp_pf [2];
    bit exp_en [2];
    int phase;
    bit final_armed;
    bit finished;
    int cyc;
    int bad;
    logic [63:0] exp_inuse;
    logic [1:0] v, hd;
    int a [2];
    int p [2];
    int used;
    logic rw;

    do_reset();
    for (int i = 0; i < 32; i++) mmap[i] = i;
    for (int i = 0; i < 64; i++) freed_cnt[i] = 0;
    for (int i = 32; i < 64; i++) pool.push_back(i);
    for (int i = 0; i < 64; i++) begin
      int j, t;
      j = int'($urandom_range(0, 31));
      t = pool[i % 32]; pool[i % 32] = pool[j]; pool[j] = t;
    end
    exp_en = '{0, 0}; exp_pf = '{0, 0};
    phase = 0; final_armed = 0; finished = 0; cyc = 0;

    while (!finished && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (free_en[i] !== exp_en[i] || (exp_en[i] && preg_to_free[i] !== PREG'(exp_pf[i]))) begin
          errors++;
          $display("FAIL rand_free[%0d] cyc %0d: got en=%b preg=%0d expected en=%b preg=%0d",
                   i, cyc, free_en[i], preg_to_free[i], exp_en[i], exp_pf[i]);
        end
        if (free_en[i] === 1'b1) freed_cnt[preg_to_free[i]]++;
      end
      checks++;
      if (ret_ready !== (phase == 0)) begin errors++; $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, ret_ready, phase == 0); end
      checks++;
      if (recover_valid !== (phase == 2)) begin errors++; $display("FAIL rand_recover cyc %0d: got %b expected %b", cyc, recover_valid, phase == 2); end
      if (phase == 2) begin
        exp_inuse = '0;
        for (int x = 0; x < 32; x++) exp_inuse[mmap[x]] = 1'b1;
        exp_inuse[0] = 1'b1;
        checks++;
        if (recover_inuse !== exp_inuse) begin errors++; $display("FAIL rand_inuse cyc %0d: got %h expected %h", cyc, recover_inuse, exp_inuse); end
        if (final_armed) begin
          bad = 0;
          for (int q = 0; q < 64; q++) begin
            if (freed_cnt[q] > 1) bad++;
            else if ((freed_cnt[q] == 1) == (recover_inuse[q] === 1'b1)) bad++;
          end
          checks++;
          if (bad != 0) begin errors++; $display("FAIL rand_partition: got %0d bad pregs expected 0", bad); end
          finished = 1;
        end
      end

      v  = 2'($urandom);
      hd = 2'($urandom);
      rw = ($urandom_range(0, 15) == 0);
      used = 0;
      for (int i = 0; i < 2; i++) begin
        a[i] = int'($urandom_range(0, 31));
        p[i] = int'($urandom_range(0, 63));
        if (v[i] && hd[i]) begin
          if (used < pool.size()) begin p[i] = pool[used]; used++; end
          else v[i] = 1'b0;
        end
      end
      if (pool.size() == 0 && phase == 0) begin
        v = 2'b00; rw = 1'b1; final_armed = 1;
      end
      ret_valid = v; ret_has_dest = hd;
      ret_areg[0] = AREG'(a[0]); ret_areg[1] = AREG'(a[1]);
      ret_preg[0] = PREG'(p[0]); ret_preg[1] = PREG'(p[1]);
      rewind = rw;

      for (int i = 0; i < 2; i++) begin
        exp_en[i] = 0;
        exp_pf[i] = 0;
        if (phase == 0 && v[i] && hd[i]) begin
          exp_pf[i] = mmap[a[i]];
          exp_en[i] = (mmap[a[i]] != 0);
          mmap[a[i]] = p[i];
        end
      end
      if (phase == 0) for (int k = 0; k < used; k++) void'(pool.pop_front());
      if (phase == 0) phase = rw ? 1 : 0;
      else if (phase == 1) phase = 2;
      else phase = 0;
    end

    checks++;
    if (!finished) begin errors++; $display("FAIL rand_timeout: got %0d cycles expected final recovery", cyc); end
    bad = 0;
    for (int x = 0; x < 32; x++) if (arch_map[x] !== PREG'(mmap[x])) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_final_map: got %0d differing entries expected 0", bad); end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_areg();
    test_preg0();
    test_rewind();
    test_reset_recover();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/retire_map.md
RETIRE_MAP -- requirements
Module: retire_map

Interface
REQ-001 SHALL have parameter RETIRE_PORTS, default 2, meaning the number of instructions retired per cycle.
REQ-002 SHALL have parameter NUM_AREGS, default `NUM_AREGS (32), meaning the architectural register count.
REQ-003 SHALL have parameter NUM_PREGS, default `NUM_PREGS (64), meaning the physical register count.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port ret_valid, input, [RETIRE_PORTS-1:0]: a retiring instruction is on port i; port 0 is the older.
REQ-007 SHALL have port ret_has_dest, input, [RETIRE_PORTS-1:0]: the retiring instruction writes a register.
REQ-008 SHALL have port ret_areg, input, AREG [RETIRE_PORTS-1:0]: destination architectural register.
REQ-009 SHALL have port ret_preg, input, PREG [RETIRE_PORTS-1:0]: physical register newly committed to ret_areg.
REQ-010 SHALL have port rewind, input, 1 bit: single-cycle pulse requesting squash recovery.
REQ-011 SHALL have port preg_to_free, output, PREG [RETIRE_PORTS-1:0]: physical registers returned to the free list.
REQ-012 SHALL have port free_en, output, [RETIRE_PORTS-1:0]: preg_to_free[i] is valid this cycle.
REQ-013 SHALL have port ret_ready, output, 1 bit: retirement is accepted this cycle.
REQ-014 SHALL have port recover_valid, output, 1 bit: recover_inuse is valid; a single-cycle pulse.
REQ-015 SHALL have port recover_inuse, output, [NUM_PREGS-1:0]: bitvector of physical registers held by the architectural map.
REQ-016 SHALL have port arch_map, output, PREG [NUM_AREGS-1:0]: current committed map, used by the rename map table on rewind.

Function
REQ-017 SHALL hold a committed map with one PREG entry per areg.
- A retire on port i with valid&has_dest&ret_ready SHALL write map[ret_areg[i]] <= ret_preg[i].
REQ-018 SHALL, one cycle after a retire, present free_en[i]=1 with preg_to_free[i] equal to the preg that map[ret_areg[i]] held before that retire.
- Latency: exactly 1 cycle.
- Both outputs SHALL be registered.
REQ-019 SHALL handle both ports in one cycle naming the same areg as follows:
- port 0 frees the prior map value;
- port 1 frees ret_preg[0];
- the final map value is ret_preg[1].
REQ-020 SHALL never assert free_en for preg 0; a port whose old preg is 0 frees nothing.
REQ-021 SHALL leave free_en[i]=0 for ports that are invalid or have no destination.
REQ-022 SHALL implement the FSM states RUN, DRAIN and RECOVER.
- RUN: ret_ready=1.
- rewind in RUN goes to DRAIN.
- DRAIN (1 cycle): ret_ready=0; the frees from the previous cycle's retire still issue; go to RECOVER.
- RECOVER (1 cycle): recover_valid=1, recover_inuse = OR of onehot(map[a]) over all a, with bit 0 always set; go to RUN.
REQ-023 SHALL ignore retirement while ret_ready=0; the upstream stage holds the instructions.
REQ-024 SHALL treat a rewind arriving in the same cycle as a retire as follows: the retire commits first, and its frees issue in DRAIN.
REQ-025 SHALL ignore rewind while in DRAIN or RECOVER.
REQ-026 SHALL drive arch_map combinationally from the map registers.

Reset
REQ-027 SHALL, on reset_n low and without waiting for clock, set:
- map[a] = a for every areg a;
- state = RUN;
- free_en = 0, preg_to_free = 0, recover_valid = 0;
- ret_ready = 1 only after reset_n deasserts.
REQ-028 SHALL, when reset asserts mid-RECOVER, abort recovery and emit no recover_valid.

Structure
REQ-029 SHALL take AREG, PREG, `NUM_AREGS and `NUM_PREGS from the shared sys_defs package; the FSM state enum SHALL also live there.
REQ-030 SHALL contain one sub-module, retire_bypass: combinational old-preg selection for each port, including the same-areg forwarding between ports.

Verification
REQ-031 Reset then retire port0 (areg 5, preg 40) -> next cycle free_en=01, preg_to_free[0]=5; arch_map[5]=40.
REQ-032 Retire port0 (areg 3, preg 41) and port1 (areg 3, preg 42) together -> next cycle free_en=11, frees 3 then 41; arch_map[3]=42.
REQ-033 Retire areg 0 with preg 0 mapped -> free_en[0]=0.
REQ-034 Retire (areg 7, preg 50) plus rewind in the same cycle -> DRAIN shows free 7 and ret_ready=0; next cycle recover_valid=1 with recover_inuse bit 50 set, bit 7 clear, bit 0 set.
REQ-035 Assert reset_n low during RECOVER -> outputs clear immediately; recover_valid never pulses; map returns to identity.
REQ-036 Random 2-wide retire stream checked against a reference model -> every freed preg is freed exactly once, and the freed set plus recover_inuse partition all pregs.
